core_run_ctrl: RTL



---
 rtl/core_run_ctrl_if.sv | 24 ++
 rtl/core_run_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl_if.sv
// Control/status bundle between the run controller (slave) and whoever
// starts/halts runs and watches progress (master).
interface core_run_ctrl_if #(
    parameter int NUM_RST = 2,
    parameter int CNT_W   = 16
);
    logic               start;
    logic               halt_req;
    logic [NUM_RST-1:0] core_rst_n;
    logic               core_ce;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               running;
    logic               done;

    modport master (
        output start, halt_req,
        input  core_rst_n, core_ce, cycle_cnt, running, done
    );

    modport slave (
        input  start, halt_req,
        output core_rst_n, core_ce, cycle_cnt, running, done
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Run controller for the RISC core: synchronised reset release, staged
// channel resets, divided clock-enable, cycle budget and halt handling.
module core_run_ctrl #(
    parameter int RST_HOLD   = 4,
    parameter int NUM_RST    = 2,
    parameter int STAGE_GAP  = 4,
    parameter int DIV        = 1,
    parameter int RUN_CYCLES = 200,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    core_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {HOLD, RELEASE, IDLE, RUN, DONE} state_t;

    localparam int TMR_MAX = (RST_HOLD > STAGE_GAP) ? RST_HOLD : STAGE_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(RUN_CYCLES);

    if (RUN_CYCLES < 0 || 64'(RUN_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_budget
        $error("core_run_ctrl: RUN_CYCLES does not fit in CNT_W bits");
    end
    if ($bits(bus.cycle_cnt) != CNT_W || $bits(bus.core_rst_n) != NUM_RST) begin : g_bad_if
        $error("core_run_ctrl: interface widths do not match parameters");
    end

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic               rst_sync;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [NUM_RST-1:0] core_rst_n_q, core_rst_n_d;
    logic               core_ce_q, core_ce_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic [NUM_RST-1:0] rel_shift;
    logic [CNT_W-1:0]   cnt_inc;
    logic               budget_hit;

    // Assertion is immediate through the async clear; only release is synchronised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end
    assign rst_sync = sync_q[1];

    // Each release step shifts one more '1' in from bit 0.
    genvar gi;
    for (gi = 0; gi < NUM_RST; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign rel_shift[gi] = 1'b1;
        end else begin : g_next
            assign rel_shift[gi] = core_rst_n_q[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HOLD;
            tmr_q        <= '0;
            div_q        <= '0;
            core_rst_n_q <= '0;
            core_ce_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            div_q        <= div_d;
            core_rst_n_q <= core_rst_n_d;
            core_ce_q    <= core_ce_d;
            cycle_cnt_q  <= cycle_cnt_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        div_d        = div_q;
        core_rst_n_d = core_rst_n_q;
        core_ce_d    = 1'b0;
        cycle_cnt_d  = cycle_cnt_q;
        budget_hit   = 1'b0;
        cnt_inc      = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 1'b1;

        case (state_q)
            HOLD: begin
                if (rst_sync) begin
                    if (tmr_q == TMR_W'(RST_HOLD - 1)) begin
                        tmr_d        = '0;
                        core_rst_n_d = rel_shift;
                        state_d      = rel_shift[NUM_RST-1] ? IDLE : RELEASE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (tmr_q == TMR_W'(STAGE_GAP - 1)) begin
                    tmr_d        = '0;
                    core_rst_n_d = rel_shift;
                    if (rel_shift[NUM_RST-1]) begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    cycle_cnt_d = '0;
                    div_d       = '0;
                    core_ce_d   = 1'b1;
                end
            end
            RUN: begin
                // The enable already presented this cycle counts even when halting.
                if (core_ce_q) begin
                    cycle_cnt_d = cnt_inc;
                    budget_hit  = (RUN_CYCLES != 0) && (cnt_inc == BUDGET);
                end
                div_d = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + 1'b1;
                if (bus.halt_req || budget_hit) begin
                    state_d = DONE;
                end else begin
                    core_ce_d = (div_d == '0);
                end
            end
            default: state_d = HOLD;
        endcase

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.core_ce    = core_ce_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
endmodule
